mux_sel_arbiter: RTL
====================

# mux_sel_arbiter

Four-channel round-robin arbiter that sits directly upstream of the 4:1 mux (`mux_4_1`). It produces the 2-bit `sel` that steers the mux and a one-hot `grant` back to the four requesters. A valid/ready handshake with the downstream consumer keeps `sel` stable for the whole transfer.

## Interface
- `RESET_PTR`, default 0: channel (0–3) that holds top priority after reset.
- `clk`  input  1  rising-edge clock.
- `rst_n`  input  1  asynchronous active-low reset.
- `req`  input  4  per-channel request; bit i = channel i (mux input `d<i>`).
- `ready`  input  1  downstream accepts the current mux output this cycle.
- `sel`  output  2  mux select (binary index of granted channel).
- `grant`  output  4  one-hot grant, `grant[sel]` = 1 while `valid`.
- `valid`  output  1  mux output is a granted, stable transfer.
- `lock`  input  1  only with `MUX_ARB_LOCK_EN`: keep current grant after handshake.

## Operation
- States: IDLE, GRANT.
- Reset (async, `rst_n` = 0):
  - `state` = IDLE, `sel` = 2'b00, `grant` = 4'b0000, `valid` = 0.
  - Priority pointer `ptr` = `RESET_PTR`.
  - All outputs change immediately on reset assertion, not at the next edge.
- IDLE:
  - If `req` != 0, pick the first set bit scanning `ptr`, `ptr`+1, … (mod 4).
  - Register `sel`/`grant`, set `valid`, go to GRANT.
  - If `req` == 0, stay in IDLE with `valid` = 0.
- GRANT, `ready` = 0: hold `sel`, `grant` and `valid` unchanged. The grant is never withdrawn, even if the granted `req` bit drops.
- GRANT, `ready` = 1 (handshake):
  - `ptr` <= `sel` + 1 (2-bit wrap, 3 → 0).
  - Re-arbitrate in the same edge from the new pointer against the current `req`. The just-served channel has lowest priority.
  - If any request is set, load the new grant and stay in GRANT with `valid` = 1 (no bubble).
  - Otherwise go to IDLE and clear `valid`/`grant`. `sel` keeps its last value.
- `sel` and `grant` change only on a handshake edge or on an IDLE→GRANT edge.
- Reset asserted mid-transfer aborts the transfer. Nothing is retained.

## Timing
- Request-to-grant latency: 1 cycle. `req` sampled at edge k gives `valid`/`sel` visible after edge k.
- All outputs are registered. `ready` and `req` are sampled only at the rising edge.
- With all four requests held and `ready` = 1, throughput is 1 grant/cycle in order ptr, ptr+1, ptr+2, ptr+3.
- Single requester held with `ready` = 1: granted every cycle.
- `req` = 0 at the handshake edge: `valid` = 0 the next cycle.

## Configuration
- `MUX_ARB_LOCK_EN` defined:
  - The `lock` port exists.
  - On a handshake with `lock` = 1, `sel`/`grant` are retained and `valid` stays 1, regardless of other requests.
  - `ptr` is not advanced.
  - Handshake with `lock` = 0 behaves as normal.
- Not defined: no `lock` port; every handshake re-arbitrates.

## Structure
- Shared package `mux_arb_pkg`: `N_CH` = 4, `SEL_W` = 2, state encoding (IDLE = 1'b0, GRANT = 1'b1).
- Sub-module `rr_pick`: combinational rotate-priority picker (`req`, `ptr` → `any`, `idx`). Used for both the IDLE and handshake arbitration paths.
- Top: state/pointer/output registers, plus `grant` = one-hot decode of `sel` gated by `valid`.

## Test plan
- Reset: `rst_n` = 0 asynchronously mid-cycle with `req` = 4'b1111 → `valid` = 0, `grant` = 0, `sel` = 0 immediately; first grant after release is channel 0.
- Single request: `req` = 4'b0100, `ready` = 0 for 3 cycles then 1 → `sel` = 2 and `grant` = 4'b0100 stable for 4 cycles; `valid` drops the cycle after `req` clears.
- Fairness: `req` = 4'b1111, `ready` = 1 for 8 cycles → `sel` sequence 0,1,2,3,0,1,2,3, no bubbles.
- Pointer wrap: grant channel 3, then `req` = 4'b1001 → next `sel` = 0; then `sel` = 3.
- Backpressure with changing requests: granted channel 1, `ready` = 0, `req` toggles to 4'b1000 → `sel` stays 1 until `ready`; next grant is 3.
- `MUX_ARB_LOCK_EN`: `req` = 4'b0011, `lock` = 1, `ready` = 1 for 3 cycles → `sel` = 0 held; then `lock` = 0 → `sel` = 1 on the next cycle.

Source files
------------

// File: rtl/mux_sel_arbiter_pkg.sv
// Shared types and sizes for the mux select arbiter.
// Channel count, select width and FSM state encoding.
package mux_arb_pkg;

  localparam int N_CH  = 4;
  localparam int SEL_W = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  function automatic logic [N_CH-1:0] onehot(
    input logic [SEL_W-1:0] s
  );
    return N_CH'(1) << s;
  endfunction

endpackage

// File: rtl/mux_sel_arbiter_if.sv
// Requester/consumer bundle of the mux select arbiter.
// Optional lock signal exists only with MUX_ARB_LOCK_EN.
interface mux_sel_arbiter_if;
  import mux_arb_pkg::*;

  logic [N_CH-1:0]  req;
  logic             ready;
  logic [SEL_W-1:0] sel;
  logic [N_CH-1:0]  grant;
  logic             valid;
`ifdef MUX_ARB_LOCK_EN
  logic             lock;
`endif

  modport master (
    input  req,
    input  ready,
`ifdef MUX_ARB_LOCK_EN
    input  lock,
`endif
    output sel,
    output grant,
    output valid
  );

  modport slave (
    output req,
    output ready,
`ifdef MUX_ARB_LOCK_EN
    output lock,
`endif
    input  sel,
    input  grant,
    input  valid
  );

endinterface

// File: rtl/mux_sel_arbiter_rr_pick.sv
// Rotate-priority picker: first set request
// scanning ptr, ptr+1, ... modulo channel count.
module rr_pick
  import mux_arb_pkg::*;
(
  input  logic [N_CH-1:0]  i_req,
  input  logic [SEL_W-1:0] i_ptr,
  output logic             o_any,
  output logic [SEL_W-1:0] o_idx
);

  // highest offset first so the lowest offset wins
  always_comb begin
    o_any = |i_req;
    o_idx = i_ptr;
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (i_req[i_ptr + SEL_W'(k)])
        o_idx = i_ptr + SEL_W'(k);
    end
  end

endmodule

// File: rtl/mux_sel_arbiter.sv
// Round-robin select/grant generator for a 4:1 mux.
// Optional grant lock on handshake: MUX_ARB_LOCK_EN.
module mux_sel_arbiter
  import mux_arb_pkg::*;
#(
  parameter int RESET_PTR = 0
) (
  input logic              clk,
  input logic              rst_n,
  mux_sel_arbiter_if.master bus
);

  state_t           r_state;
  state_t           w_state_n;
  logic [SEL_W-1:0] r_ptr;
  logic [SEL_W-1:0] w_ptr_n;
  logic [SEL_W-1:0] r_sel;
  logic [SEL_W-1:0] w_sel_n;
  logic             r_valid;
  logic             w_valid_n;

  logic             w_idle_any;
  logic [SEL_W-1:0] w_idle_idx;
  logic [SEL_W-1:0] w_hs_ptr;
  logic             w_hs_any;
  logic [SEL_W-1:0] w_hs_idx;
  logic             w_lock;

`ifdef MUX_ARB_LOCK_EN
  assign w_lock = bus.lock;
`else
  assign w_lock = 1'b0;
`endif

  // just-served channel drops to lowest priority
  assign w_hs_ptr = r_sel + SEL_W'(1);

  rr_pick u_idle_pick (
    .i_req (bus.req),
    .i_ptr (r_ptr),
    .o_any (w_idle_any),
    .o_idx (w_idle_idx)
  );

  rr_pick u_hs_pick (
    .i_req (bus.req),
    .i_ptr (w_hs_ptr),
    .o_any (w_hs_any),
    .o_idx (w_hs_idx)
  );

  // next-state, pointer and select decisions
  always_comb begin
    w_state_n = r_state;
    w_ptr_n   = r_ptr;
    w_sel_n   = r_sel;
    w_valid_n = r_valid;
    unique case (r_state)
      IDLE: begin
        w_valid_n = 1'b0;
        if (w_idle_any) begin
          w_sel_n   = w_idle_idx;
          w_valid_n = 1'b1;
          w_state_n = GRANT;
        end
      end
      GRANT: begin
        if (bus.ready && !w_lock) begin
          w_ptr_n = w_hs_ptr;
          if (w_hs_any) begin
            w_sel_n   = w_hs_idx;
            w_valid_n = 1'b1;
          end else begin
            w_valid_n = 1'b0;
            w_state_n = IDLE;
          end
        end
      end
      default: begin
        w_state_n = IDLE;
        w_valid_n = 1'b0;
      end
    endcase
  end

  // state, pointer and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ptr   <= SEL_W'(RESET_PTR);
      r_sel   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_ptr   <= w_ptr_n;
      r_sel   <= w_sel_n;
      r_valid <= w_valid_n;
    end
  end

  assign bus.sel   = r_sel;
  assign bus.valid = r_valid;
  assign bus.grant = r_valid ? onehot(r_sel) : '0;

endmodule
